ram_sdp_fill: RTL

//  Parametrised simple-dual-port synchronous RAM (one write port, one read port) with byte-lane

---
 rtl/ram_sdp_fill_pkg.sv | 15 +
 rtl/ram_sdp_fill_if.sv | 30 +++
 rtl/ram_sdp_core.sv | 62 ++++++
 rtl/ram_sdp_fill.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ram_sdp_fill_pkg.sv
// Shared definitions for the simple-dual-port RAM with fill engine.
//   fill_state_e : fill engine states (idle / filling)
//   RDW_MODE_*   : values for the RDW_NEW parameter of the RAM blocks
package ram_sdp_fill_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  // Same-address read during write: return the stored word, or the merged new word.
  localparam bit RDW_MODE_OLD = 1'b0;
  localparam bit RDW_MODE_NEW = 1'b1;

endpackage

// File: rtl/ram_sdp_fill_if.sv
// Bus bundle for ram_sdp_fill: write port, read port and fill control.
//   master : drives we/waddr/wdata/wbe, re/raddr and fill_req; observes rdata/rvalid/busy
//   slave  : the RAM side of the same signals
interface ram_sdp_fill_if #(
  parameter int D = 14,
  parameter int W = 8
);

  logic             we;
  logic [D-1:0]     waddr;
  logic [W-1:0]     wdata;
  logic [W/8-1:0]   wbe;
  logic             re;
  logic [D-1:0]     raddr;
  logic [W-1:0]     rdata;
  logic             rvalid;
  logic             fill_req;
  logic             busy;

  modport master (
    output we, waddr, wdata, wbe, re, raddr, fill_req,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  we, waddr, wdata, wbe, re, raddr, fill_req,
    output rdata, rvalid, busy
  );

endinterface

// File: rtl/ram_sdp_core.sv
// Storage array for ram_sdp_fill: byte-lane write port, registered read port and
// the same-address read-during-write bypass.
//   clk, reset           : clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata/wbe   : write port, lane i written iff we & wbe[i]
//   re/raddr             : read strobe and address
//   rdata                : registered read data, holds when re is low
module ram_sdp_core
  import ram_sdp_fill_pkg::*;
#(
  parameter int D       = 14,
  parameter int W       = 8,
  parameter bit RDW_NEW = RDW_MODE_OLD
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           we,
  input  logic [D-1:0]   waddr,
  input  logic [W-1:0]   wdata,
  input  logic [W/8-1:0] wbe,
  input  logic           re,
  input  logic [D-1:0]   raddr,
  output logic [W-1:0]   rdata
);

  localparam int LANES = W / 8;
  localparam int DEPTH = 1 << D;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_word;
  logic [W-1:0] rdata_d;
  logic [W-1:0] rdata_q;

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM;
  // clearing it is the job of the fill engine, not of the reset net.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // NOTE: every signal written here gets a value before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    rd_word = mem[raddr];
    if (RDW_NEW == RDW_MODE_NEW && we && (waddr == raddr)) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) rd_word[i*8 +: 8] = wdata[i*8 +: 8];
      end
    end
    rdata_d = re ? rd_word : rdata_q;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_sdp_fill.sv
// Simple-dual-port RAM with byte-lane writes, optional output register and a
// fill engine that writes FILL to every word after reset or on fill_req.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : ram_sdp_fill_if slave (write port, read port, fill_req, busy)
// The fill engine owns the write port while busy; user writes are then dropped.
module ram_sdp_fill
  import ram_sdp_fill_pkg::*;
#(
  parameter int         D           = 14,
  parameter int         W           = 8,
  parameter bit         RDW_NEW     = RDW_MODE_OLD,
  parameter bit         OUT_REG     = 1'b0,
  parameter logic [W-1:0] FILL      = '0,
  parameter bit         FILL_ON_RST = 1'b1
) (
  input logic            clk,
  input logic            reset,
  ram_sdp_fill_if.slave  bus
);

  localparam fill_state_e RST_STATE = FILL_ON_RST ? ST_FILL : ST_IDLE;

  fill_state_e    state_q, state_d;
  logic [D-1:0]   fill_cnt_q, fill_cnt_d;
  logic           busy_q, busy_d;
  logic           rv1_q, rv1_d;

  logic           core_we;
  logic [D-1:0]   core_waddr;
  logic [W-1:0]   core_wdata;
  logic [W/8-1:0] core_wbe;
  logic [W-1:0]   core_rdata;

  // Fill sequencing: one word per cycle; the counter wraps back to 0 as the
  // last address is written, ready for the next fill.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    unique case (state_q)
      ST_IDLE: if (bus.fill_req) state_d = ST_FILL;
      ST_FILL: begin
        fill_cnt_d = fill_cnt_q + D'(1);
        if (fill_cnt_q == '1) state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_FILL);
    rv1_d  = bus.re;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RST_STATE;
      fill_cnt_q <= '0;
      busy_q     <= FILL_ON_RST;
      rv1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      busy_q     <= busy_d;
      rv1_q      <= rv1_d;
    end
  end

  // Write-port arbitration: the fill engine wins outright, user writes are not queued.
  always_comb begin
    if (busy_q) begin
      core_we    = 1'b1;
      core_waddr = fill_cnt_q;
      core_wdata = FILL;
      core_wbe   = '1;
    end else begin
      core_we    = bus.we;
      core_waddr = bus.waddr;
      core_wdata = bus.wdata;
      core_wbe   = bus.wbe;
    end
  end

  ram_sdp_core #(
    .D       (D),
    .W       (W),
    .RDW_NEW (RDW_NEW)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .wbe   (core_wbe),
    .re    (bus.re),
    .raddr (bus.raddr),
    .rdata (core_rdata)
  );

  if (OUT_REG) begin : g_out_reg
    logic [W-1:0] rdata2_q, rdata2_d;
    logic         rv2_q, rv2_d;

    always_comb begin
      rv2_d    = rv1_q;
      rdata2_d = rv1_q ? core_rdata : rdata2_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rdata2_q <= '0;
        rv2_q    <= 1'b0;
      end else begin
        rdata2_q <= rdata2_d;
        rv2_q    <= rv2_d;
      end
    end

    assign bus.rdata  = rdata2_q;
    assign bus.rvalid = rv2_q;
  end else begin : g_no_out_reg
    assign bus.rdata  = core_rdata;
    assign bus.rvalid = rv1_q;
  end

  assign bus.busy = busy_q;

endmodule
